// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: response codes, run-mode encodings and FSM state type shared by the traffic generator
package axi_lite_pkg;
  localparam logic [1:0] OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11;
  typedef enum logic [1:0] {
    MODE_WR = 2'b00,
    MODE_RD = 2'b01,
    MODE_WR_RD = 2'b10,
    MODE_WR_RD_EACH = 2'b11
  } mode_e;
  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, NEXT, FIN} state_e;
endpackage

// File: rtl/axi_lite_watchdog.sv
// axi_lite_watchdog: per-transaction wait-cycle counter
// ports: aclk/areset clock and sync reset, clear restarts the count, enable counts one cycle, expired registered flag
module axi_lite_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic aclk,
  input  logic areset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [31:0] cnt;
  // expired rises one cycle early so the FSM acts during the TIMEOUT-th waiting cycle
  always_ff @(posedge aclk)
    if (areset || clear) begin
      cnt <= '0;
      expired <= 1'b0;
    end else if (enable) begin
      cnt <= cnt + 32'd1;
      expired <= cnt + 32'd2 >= 32'(TIMEOUT);
    end
endmodule

// File: rtl/axi_lite_traffic_gen.sv
// axi_lite_traffic_gen: issues a run of patterned AXI-lite writes/reads to a master and checks the responses
// ports: aclk/areset clock and sync reset; start/mode run request; busy/done/pass/err_cnt/first_err_addr/timeout_flag status;
//        wr_req/wr_addr/wr_data/wr_strb + wr_done/wr_resp write channel; rd_req/rd_addr + rd_done/rd_data/rd_resp read channel
module axi_lite_traffic_gen
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_XFER = 16,
  parameter longint BASE_ADDR = 0,
  parameter int ADDR_STRIDE = DATA_W / 8,
  parameter PATTERN_BASE = 32'hA5A5_0000,
  parameter int TIMEOUT = 256
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [8:0]            err_cnt,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic                  timeout_flag,
  output logic                  wr_req,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W/8-1:0]   wr_strb,
  input  logic                  wr_done,
  input  logic [1:0]            wr_resp,
  output logic                  rd_req,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_done,
  input  logic [DATA_W-1:0]     rd_data,
  input  logic [1:0]            rd_resp
);
  state_e state, state_nxt;
  mode_e mode_q;
  logic [7:0] idx, idx_nxt;
  logic last, last_rd, in_wait, accept, bad, expired, timeout_hit, err_inc;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  assign cur_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(idx) * ADDR_W'(ADDR_STRIDE);
  assign cur_data = DATA_W'(PATTERN_BASE) ^ {(DATA_W / 8){idx}};
  assign last = idx == 8'(NUM_XFER - 1);
  assign in_wait = state == WR_WAIT || state == RD_WAIT;
  // a done arriving in the same cycle as the request pulse belongs to nothing we issued
  assign accept = state == WR_WAIT ? wr_done && !wr_req : state == RD_WAIT && rd_done && !rd_req;
  assign bad = state == WR_WAIT ? wr_resp != OKAY
             : rd_resp != OKAY || (mode_q != MODE_RD && rd_data != cur_data);
  assign timeout_hit = in_wait && !accept && expired;
  assign err_inc = (accept && bad) || timeout_hit;
  assign busy = !(state == IDLE || state == FIN);
  assign done = state == FIN;
  assign pass = done && err_cnt == '0 && !timeout_flag;
  axi_lite_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .aclk   (aclk),
    .areset (areset),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(expired)
  );
  always_ff @(posedge aclk) state <= areset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    case (state)
      IDLE, FIN: if (start) state_nxt = mode == MODE_RD ? RD_ISSUE : WR_ISSUE;
      WR_ISSUE: state_nxt = WR_WAIT;
      RD_ISSUE: state_nxt = RD_WAIT;
      WR_WAIT, RD_WAIT: state_nxt = accept ? NEXT : expired ? FIN : state;
      NEXT: begin
        case (mode_q)
          MODE_WR: state_nxt = last ? FIN : WR_ISSUE;
          MODE_RD: state_nxt = last ? FIN : RD_ISSUE;
          MODE_WR_RD: state_nxt = last_rd ? (last ? FIN : RD_ISSUE) : (last ? RD_ISSUE : WR_ISSUE);
          default: state_nxt = last_rd ? (last ? FIN : WR_ISSUE) : RD_ISSUE;
        endcase
        // the index only wraps at the write-to-read turnaround; per-address mode reads the same index it wrote
        idx_nxt = (state_nxt == FIN || (mode_q == MODE_WR_RD_EACH && !last_rd)) ? idx
                : last ? 8'd0 : idx + 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      mode_q <= MODE_WR;
      idx <= '0;
      last_rd <= 1'b0;
      wr_req <= 1'b0;
      rd_req <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_strb <= '0;
      rd_addr <= '0;
      err_cnt <= '0;
      first_err_addr <= '0;
      timeout_flag <= 1'b0;
    end else begin
      wr_req <= state == WR_ISSUE;
      rd_req <= state == RD_ISSUE;
      idx <= idx_nxt;
      if (state == WR_ISSUE) begin
        wr_addr <= cur_addr;
        wr_data <= cur_data;
        wr_strb <= '1;
      end
      if (state == RD_ISSUE) rd_addr <= cur_addr;
      if (in_wait) last_rd <= state == RD_WAIT;
      if ((state == IDLE || state == FIN) && start) begin
        mode_q <= mode_e'(mode);
        idx <= '0;
        err_cnt <= '0;
        first_err_addr <= '0;
        timeout_flag <= 1'b0;
      end
      if (err_inc) begin
        if (err_cnt != 9'd511) err_cnt <= err_cnt + 9'd1;
        if (err_cnt == '0) first_err_addr <= state == WR_WAIT ? wr_addr : rd_addr;
      end
      if (timeout_hit) timeout_flag <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_lite_traffic_gen.sv
// tb_axi_lite_traffic_gen: scoreboard bench with a responding memory model for axi_lite_traffic_gen
module tb_axi_lite_traffic_gen;
  localparam int N = 4;
  localparam int TMO = 16;
  localparam logic [31:0] PAT = 32'hA5A5_0000;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;
  typedef struct {
    bit rd;
    logic [31:0] addr;
    logic [31:0] data;
  } tx_t;
  logic aclk = 1'b0, areset = 1'b1, start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic busy, done, pass, timeout_flag, wr_req, rd_req;
  logic [8:0] err_cnt;
  logic [31:0] first_err_addr, wr_addr, wr_data, rd_addr;
  logic [3:0] wr_strb;
  logic wr_done = 1'b0, rd_done = 1'b0;
  logic [1:0] wr_resp = 2'd0, rd_resp = 2'd0;
  logic [31:0] rd_data = '0;
  int checks = 0, failures = 0, reqs = 0, epoch = 0;
  int min_dly = 1, max_dly = 6;
  bit garbage = 0, no_resp = 0, early_done = 0;
  logic [31:0] slverr_rd = NONE, slverr_wr = NONE, corrupt_rd = NONE;
  tx_t exp_q[$];
  logic [31:0] mem[logic [31:0]];

  axi_lite_traffic_gen #(.NUM_XFER(N), .TIMEOUT(TMO)) dut (
    .aclk(aclk), .areset(areset), .start(start), .mode(mode),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .timeout_flag(timeout_flag),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_done(wr_done), .wr_resp(wr_resp),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_done(rd_done), .rd_data(rd_data), .rd_resp(rd_resp)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return PAT ^ (32'(i) * 32'h0101_0101);
  endfunction

  // monitor: every request the DUT presents is matched in order against the expected transaction list
  initial forever begin
    tx_t t;
    @(negedge aclk);
    if (wr_req || rd_req) begin
      reqs++;
      chk("req_exclusive", {31'd0, wr_req && rd_req}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_req: got wr=%0d rd=%0d addr %h/%h expected none", wr_req, rd_req, wr_addr, rd_addr);
      end else begin
        t = exp_q.pop_front();
        chk("req_kind", {63'd0, rd_req}, {63'd0, t.rd});
        chk("req_addr", t.rd ? rd_addr : wr_addr, t.addr);
        if (!t.rd) begin
          chk("wr_data", wr_data, t.data);
          chk("wr_strb", wr_strb, 4'hF);
        end
      end
    end
  end

  // responder: memory model with configurable faults and random latency
  initial forever begin
    bit rd;
    logic [31:0] a, d;
    int dl, e;
    @(negedge aclk);
    if ((wr_req || rd_req) && !no_resp) begin
      rd = rd_req;
      a = rd ? rd_addr : wr_addr;
      d = wr_data;
      e = epoch;
      dl = $urandom_range(min_dly, max_dly);
      if (early_done) begin
        if (rd) begin rd_done = 1'b1; rd_resp = 2'b10; rd_data = '0; end
        else begin wr_done = 1'b1; wr_resp = 2'b10; end
        @(negedge aclk);
        wr_done = 1'b0; rd_done = 1'b0; wr_resp = 2'd0; rd_resp = 2'd0;
        dl--;
      end
      repeat (dl) @(negedge aclk);
      if (rd) begin
        rd_data = garbage ? $urandom : a == corrupt_rd ? 32'd0 : mem.exists(a) ? mem[a] : $urandom;
        rd_resp = a == slverr_rd ? 2'b10 : 2'b00;
        rd_done = 1'b1;
        if (e == epoch) chk("rd_addr_held", rd_addr, a);
      end else begin
        mem[a] = d;
        wr_resp = a == slverr_wr ? 2'b10 : 2'b00;
        wr_done = 1'b1;
        if (e == epoch) begin
          chk("wr_addr_held", wr_addr, a);
          chk("wr_data_held", wr_data, d);
        end
      end
      @(negedge aclk);
      wr_done = 1'b0; rd_done = 1'b0; wr_resp = 2'd0; rd_resp = 2'd0; rd_data = '0;
    end
  end

  task automatic clear_faults();
    slverr_rd = NONE; slverr_wr = NONE; corrupt_rd = NONE;
    garbage = 0; no_resp = 0; early_done = 0; min_dly = 1; max_dly = 6;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {45'd0, busy, done, pass, err_cnt, timeout_flag, wr_req, rd_req, wr_strb}, 64'd0);
    chk({tag, "_addr"}, {first_err_addr, wr_addr}, 64'd0);
    chk({tag, "_data"}, {wr_data, rd_addr}, 64'd0);
  endtask

  task automatic run(input logic [1:0] m);
    tx_t seq[$];
    int n_err = 0;
    logic [31:0] first = '0;
    bit ok = 0;
    mem.delete();
    for (int i = 0; i < N; i++) begin
      if (m != 2'd1) seq.push_back('{rd: 1'b0, addr: 32'(4 * i), data: pat(i)});
      if (m == 2'd1 || m == 2'd3) seq.push_back('{rd: 1'b1, addr: 32'(4 * i), data: pat(i)});
    end
    if (m == 2'd2) for (int i = 0; i < N; i++) seq.push_back('{rd: 1'b1, addr: 32'(4 * i), data: pat(i)});
    foreach (seq[k]) begin
      bit bad;
      bad = seq[k].rd ? (seq[k].addr == slverr_rd || (m != 2'd1 && seq[k].addr == corrupt_rd))
                      : seq[k].addr == slverr_wr;
      if (bad) begin
        if (n_err == 0) first = seq[k].addr;
        n_err++;
      end
      exp_q.push_back(seq[k]);
    end
    mode = m;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    mode = 2'($urandom);
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge aclk);
      if (c == 3 && busy) begin
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
      end
      ok = done;
    end
    chk("run_done", {63'd0, ok}, 64'd1);
    chk("err_cnt", err_cnt, n_err);
    chk("first_err_addr", first_err_addr, first);
    chk("pass", {63'd0, pass}, {63'd0, n_err == 0});
    chk("timeout_flag", {63'd0, timeout_flag}, 64'd0);
    chk("sb_drained", exp_q.size(), 64'd0);
    repeat (3) @(negedge aclk);
    chk("done_hold", {62'd0, done, busy}, 64'd2);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit seen;
    int r0;
    repeat (3) @(negedge aclk);
    chk_zero("reset_hold");
    areset = 1'b0;
    @(negedge aclk);
    chk_zero("reset_idle");

    run(2'd0);
    run(2'd2);
    corrupt_rd = 32'h8;
    run(2'd3);
    clear_faults();
    slverr_rd = 32'h4;
    garbage = 1;
    run(2'd1);
    clear_faults();

    no_resp = 1;
    exp_q.push_back('{rd: 1'b0, addr: 32'h0, data: pat(0)});
    r0 = reqs;
    mode = 2'd0;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge aclk);
      seen = wr_req;
    end
    chk("tmo_req_seen", {63'd0, seen}, 64'd1);
    repeat (TMO - 1) @(negedge aclk);
    chk("tmo_flag_early", {63'd0, timeout_flag}, 64'd0);
    @(negedge aclk);
    chk("tmo_flag", {62'd0, timeout_flag, done}, 64'd3);
    chk("tmo_err_cnt", err_cnt, 64'd1);
    chk("tmo_pass", {63'd0, pass}, 64'd0);
    chk("tmo_first_addr", first_err_addr, 64'd0);
    repeat (20) @(negedge aclk);
    chk("tmo_one_req", reqs - r0, 64'd1);
    exp_q.delete();
    clear_faults();

    min_dly = 8; max_dly = 8;
    for (int i = 0; i < N; i++) exp_q.push_back('{rd: 1'b1, addr: 32'(4 * i), data: pat(i)});
    mode = 2'd1;
    start = 1'b1;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge aclk);
      seen = rd_req;
    end
    chk("rst_rd_req_seen", {63'd0, seen}, 64'd1);
    @(negedge aclk);
    areset = 1'b1;
    epoch++;
    @(negedge aclk);
    chk_zero("rst_mid");
    areset = 1'b0;
    start = 1'b0;
    exp_q.delete();
    repeat (10) @(negedge aclk);
    chk_zero("rst_late_done");
    clear_faults();
    run(2'd1);

    for (int k = 0; k < 10; k++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      slverr_rd = $urandom_range(0, 1) ? 32'(4 * $urandom_range(0, N - 1)) : NONE;
      slverr_wr = $urandom_range(0, 2) == 0 ? 32'(4 * $urandom_range(0, N - 1)) : NONE;
      corrupt_rd = $urandom_range(0, 1) ? 32'(4 * $urandom_range(0, N - 1)) : NONE;
      garbage = m == 2'd1;
      early_done = $urandom_range(0, 1) == 1;
      run(m);
      clear_faults();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
